decode_writeback: RTL and testbench

- Y86-64 decode/write-back stage directly downstream of fetch. Consumes icode, rA and rB, and holds the 15-entry 64-bit register file.
- Decode side: derives srcA, srcB, dstE and dstM; drives valA and valB to execute.
- Write-back side: commits valE and valM from execute/memory on the clock edge.
- Sequential state: the register file, plus a registered dstE/dstM pair captured at decode and used at write-back.

---
 rtl/y86_pkg.sv | 20 ++
 rtl/regfile_2r2w.sv | 38 +++
 rtl/decode_writeback.sv | 85 ++++++++
 tb/tb_decode_writeback.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 opcode, register-ID and word definitions
package y86_pkg;
   typedef logic [63:0] word_t;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [3:0] RRSP  = 4'h4;
endpackage

// File: rtl/regfile_2r2w.sv
// rtl/regfile_2r2w.sv - 15x64 register file, two read ports, debug port, two write ports
module regfile_2r2w
   import y86_pkg::*;
#(
   parameter logic [63:0] STACK_INIT = 64'd256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  ra_i,
   input  logic [3:0]  rb_i,
   input  logic [3:0]  rdbg_i,
   output logic [63:0] ra_o,
   output logic [63:0] rb_o,
   output logic [63:0] rdbg_o,
   input  logic        we_e_i,
   input  logic [3:0]  wa_e_i,
   input  logic [63:0] wd_e_i,
   input  logic        we_m_i,
   input  logic [3:0]  wa_m_i,
   input  logic [63:0] wd_m_i
);
   word_t mem_q [0:14];

   assign ra_o   = (ra_i   == RNONE) ? 64'd0 : mem_q[ra_i];
   assign rb_o   = (rb_i   == RNONE) ? 64'd0 : mem_q[rb_i];
   assign rdbg_o = (rdbg_i == RNONE) ? 64'd0 : mem_q[rdbg_i];

   // M port is written last so it wins when both target the same register
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 15; i++)
            mem_q[i] <= (i == int'(RRSP)) ? STACK_INIT : 64'd0;
      end else begin
         if (we_e_i && wa_e_i != RNONE) mem_q[wa_e_i] <= wd_e_i;
         if (we_m_i && wa_m_i != RNONE) mem_q[wa_m_i] <= wd_m_i;
      end
   end
endmodule

// File: rtl/decode_writeback.sv
// rtl/decode_writeback.sv - Y86-64 decode and write-back stage around the register file
module decode_writeback
   import y86_pkg::*;
#(
   parameter logic [63:0] STACK_INIT = 64'd256,
   parameter bit          BYPASS     = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  icode,
   input  logic [3:0]  rA,
   input  logic [3:0]  rB,
   input  logic        dec_en,
   input  logic        cnd,
   input  logic        wb_en,
   input  logic [63:0] valE,
   input  logic [63:0] valM,
   output logic [63:0] valA,
   output logic [63:0] valB,
   output logic [3:0]  srcA,
   output logic [3:0]  srcB,
   output logic [3:0]  dstE_q,
   output logic [3:0]  dstM_q,
   input  logic [3:0]  dbg_sel,
   output logic [63:0] dbg_val
);
   logic [3:0] dstE_d, dstM_d;
   word_t      rf_a, rf_b;

   always_comb begin
      srcA   = RNONE;
      srcB   = RNONE;
      dstE_d = RNONE;
      dstM_d = RNONE;
      case (icode)
         I_RRMOVQ: begin srcA = rA; dstE_d = cnd ? rB : RNONE; end
         I_IRMOVQ: dstE_d = rB;
         I_RMMOVQ: begin srcA = rA; srcB = rB; end
         I_MRMOVQ: begin srcB = rB; dstM_d = rA; end
         I_OPQ:    begin srcA = rA; srcB = rB; dstE_d = rB; end
         I_CALL:   begin srcB = RRSP; dstE_d = RRSP; end
         I_RET:    begin srcA = RRSP; srcB = RRSP; dstE_d = RRSP; end
         I_PUSHQ:  begin srcA = rA; srcB = RRSP; dstE_d = RRSP; end
         I_POPQ:   begin srcA = RRSP; srcB = RRSP; dstE_d = RRSP; dstM_d = rA; end
         default:  ;
      endcase
   end

   // Write-back on the same edge still uses the previously latched destinations
   always_ff @(posedge clk) begin
      if (rst) begin
         dstE_q <= RNONE;
         dstM_q <= RNONE;
      end else if (dec_en) begin
         dstE_q <= dstE_d;
         dstM_q <= dstM_d;
      end
   end

   regfile_2r2w #(.STACK_INIT(STACK_INIT)) u_rf (
      .clk    (clk),
      .rst    (rst),
      .ra_i   (srcA),
      .rb_i   (srcB),
      .rdbg_i (dbg_sel),
      .ra_o   (rf_a),
      .rb_o   (rf_b),
      .rdbg_o (dbg_val),
      .we_e_i (wb_en),
      .wa_e_i (dstE_q),
      .wd_e_i (valE),
      .we_m_i (wb_en),
      .wa_m_i (dstM_q),
      .wd_m_i (valM)
   );

   function automatic word_t fwd(input logic [3:0] src, input word_t rf_val);
      if (BYPASS && wb_en && src != RNONE && src == dstM_q) return valM;
      if (BYPASS && wb_en && src != RNONE && src == dstE_q) return valE;
      return rf_val;
   endfunction

   assign valA = fwd(srcA, rf_a);
   assign valB = fwd(srcB, rf_b);
endmodule

// File: tb/tb_decode_writeback.sv
// tb/tb_decode_writeback.sv - randomized self-checking bench for decode_writeback
module tb_decode_writeback;
   logic        clk = 1'b0;
   logic        rst, dec_en, cnd, wb_en;
   logic [3:0]  icode, rA, rB, dbg_sel;
   logic [63:0] valE, valM;
   logic [63:0] valA1, valB1, dbg1, valA0, valB0, dbg0;
   logic [3:0]  srcA1, srcB1, dE1, dM1, srcA0, srcB0, dE0, dM0;

   int vectors = 0;
   int miscompares = 0;

   logic [63:0] m_reg [0:14];
   logic [3:0]  m_dE, m_dM;

   always #5 clk = ~clk;

   decode_writeback dut1 (
      .clk(clk), .rst(rst), .icode(icode), .rA(rA), .rB(rB), .dec_en(dec_en),
      .cnd(cnd), .wb_en(wb_en), .valE(valE), .valM(valM), .valA(valA1), .valB(valB1),
      .srcA(srcA1), .srcB(srcB1), .dstE_q(dE1), .dstM_q(dM1), .dbg_sel(dbg_sel), .dbg_val(dbg1));

   decode_writeback #(.BYPASS(1'b0)) dut0 (
      .clk(clk), .rst(rst), .icode(icode), .rA(rA), .rB(rB), .dec_en(dec_en),
      .cnd(cnd), .wb_en(wb_en), .valE(valE), .valM(valM), .valA(valA0), .valB(valB0),
      .srcA(srcA0), .srcB(srcB0), .dstE_q(dE0), .dstM_q(dM0), .dbg_sel(dbg_sel), .dbg_val(dbg0));

   // Reference rules, expressed as opcode membership tables
   function automatic logic [3:0] e_srcA(input logic [3:0] ic, input logic [3:0] a);
      if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return a;
      if (ic inside {4'h9, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction
   function automatic logic [3:0] e_srcB(input logic [3:0] ic, input logic [3:0] b);
      if (ic inside {4'h4, 4'h5, 4'h6}) return b;
      if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction
   function automatic logic [3:0] e_dstE(input logic [3:0] ic, input logic [3:0] b, input logic c);
      if (ic inside {4'h3, 4'h6}) return b;
      if (ic == 4'h2) return c ? b : 4'hF;
      if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction
   function automatic logic [3:0] e_dstM(input logic [3:0] ic, input logic [3:0] a);
      return (ic inside {4'h5, 4'hB}) ? a : 4'hF;
   endfunction
   function automatic logic [63:0] m_read(input logic [3:0] id, input bit byp);
      if (id == 4'hF) return 64'd0;
      if (byp && wb_en && id == m_dM) return valM;
      if (byp && wb_en && id == m_dE) return valE;
      return m_reg[id];
   endfunction

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 15; i++) m_reg[i] = (i == 4) ? 64'd256 : 64'd0;
         m_dE = 4'hF; m_dM = 4'hF;
      end else begin
         if (wb_en && m_dE != 4'hF) m_reg[m_dE] = valE;
         if (wb_en && m_dM != 4'hF) m_reg[m_dM] = valM;
         if (dec_en) begin m_dE = e_dstE(icode, rB, cnd); m_dM = e_dstM(icode, rA); end
      end
      #1;
   endtask

   task automatic idle();
      dec_en = 0; wb_en = 0; rst = 0; icode = 4'h1; rA = 4'hF; rB = 4'hF; cnd = 0;
   endtask

   task automatic load_reg(input logic [3:0] r, input logic [63:0] v);
      idle(); icode = 4'h3; rB = r; dec_en = 1; tick();
      dec_en = 0; wb_en = 1; valE = v; tick();
      idle(); #1;
   endtask

   task automatic test_reset();
      idle(); rst = 1; tick(); rst = 0; dbg_sel = 4'h4; #1;
      vectors++; if (dbg1 !== 64'd256) begin miscompares++; $display("FAIL reset_rsp got %0d exp 256", dbg1); end
      dbg_sel = 4'h0; #1;
      vectors++; if (dbg1 !== 64'd0) begin miscompares++; $display("FAIL reset_r0 got %0d exp 0", dbg1); end
      dbg_sel = 4'hF; #1;
      vectors++; if (dbg1 !== 64'd0) begin miscompares++; $display("FAIL dbg_none got %h exp 0", dbg1); end
      vectors++; if (dE1 !== 4'hF || dM1 !== 4'hF) begin miscompares++; $display("FAIL reset_dst got %h/%h exp F/F", dE1, dM1); end
   endtask

   task automatic test_irmovq();
      idle(); icode = 4'h3; rB = 4'h2; dec_en = 1; #1;
      vectors++; if (srcA1 !== 4'hF || srcB1 !== 4'hF) begin miscompares++; $display("FAIL irmovq_src got %h/%h exp F/F", srcA1, srcB1); end
      tick(); dec_en = 0; wb_en = 1; valE = 64'h1234; #1;
      vectors++; if (dE1 !== 4'h2) begin miscompares++; $display("FAIL irmovq_dstE got %h exp 2", dE1); end
      tick(); idle(); dbg_sel = 4'h2; #1;
      vectors++; if (dbg1 !== 64'h1234) begin miscompares++; $display("FAIL irmovq_wb got %h exp 1234", dbg1); end
   endtask

   task automatic test_opq_bypass();
      load_reg(4'h2, 64'd5); load_reg(4'h3, 64'd7);
      icode = 4'h6; rA = 4'h2; rB = 4'h3; dec_en = 1; #1;
      vectors++; if (valA1 !== 64'd5 || valB1 !== 64'd7) begin miscompares++; $display("FAIL opq_read got %0d/%0d exp 5/7", valA1, valB1); end
      tick(); dec_en = 0; #1;
      vectors++; if (dE1 !== 4'h3) begin miscompares++; $display("FAIL opq_dstE got %h exp 3", dE1); end
      wb_en = 1; valE = 64'd12; #1;
      vectors++; if (valB1 !== 64'd12) begin miscompares++; $display("FAIL bypass_on got %0d exp 12", valB1); end
      vectors++; if (valB0 !== 64'd7) begin miscompares++; $display("FAIL bypass_off got %0d exp 7", valB0); end
      tick(); idle(); dbg_sel = 4'h3; #1;
      vectors++; if (dbg1 !== 64'd12) begin miscompares++; $display("FAIL opq_wb got %0d exp 12", dbg1); end
   endtask

   task automatic test_cmov();
      load_reg(4'h1, 64'h77); load_reg(4'h6, 64'h66);
      icode = 4'h2; rA = 4'h1; rB = 4'h6; cnd = 0; dec_en = 1; tick();
      dec_en = 0; wb_en = 1; valE = 64'h999; #1;
      vectors++; if (dE1 !== 4'hF) begin miscompares++; $display("FAIL cmov_nc_dst got %h exp F", dE1); end
      tick(); wb_en = 0; dbg_sel = 4'h6; #1;
      vectors++; if (dbg1 !== 64'h66) begin miscompares++; $display("FAIL cmov_nc_reg got %h exp 66", dbg1); end
      cnd = 1; dec_en = 1; tick(); dec_en = 0; wb_en = 1; valE = 64'h999; tick(); idle(); #1;
      vectors++; if (dbg1 !== 64'h999) begin miscompares++; $display("FAIL cmov_c_reg got %h exp 999", dbg1); end
   endtask

   task automatic test_popq_rsp();
      idle(); icode = 4'hB; rA = 4'h4; dec_en = 1; tick(); dec_en = 0; #1;
      vectors++; if (dE1 !== 4'h4 || dM1 !== 4'h4) begin miscompares++; $display("FAIL popq_dst got %h/%h exp 4/4", dE1, dM1); end
      icode = 4'h9; wb_en = 1; valE = 64'd264; valM = 64'hABCD; #1;
      vectors++; if (valA1 !== 64'hABCD) begin miscompares++; $display("FAIL popq_bypass got %h exp abcd", valA1); end
      tick(); idle(); dbg_sel = 4'h4; #1;
      vectors++; if (dbg1 !== 64'hABCD) begin miscompares++; $display("FAIL popq_reg got %h exp abcd", dbg1); end
   endtask

   task automatic test_reset_midwb();
      idle(); icode = 4'h3; rB = 4'h2; dec_en = 1; tick();
      dec_en = 0; wb_en = 1; valE = 64'h55; rst = 1; tick(); idle(); dbg_sel = 4'h2; #1;
      vectors++; if (dbg1 !== 64'd0) begin miscompares++; $display("FAIL rst_wb_r2 got %h exp 0", dbg1); end
      dbg_sel = 4'h4; #1;
      vectors++; if (dbg1 !== 64'd256) begin miscompares++; $display("FAIL rst_wb_rsp got %0d exp 256", dbg1); end
      icode = 4'hE; rA = 4'h1; rB = 4'h2; dec_en = 1; #1;
      vectors++; if (srcA1 !== 4'hF || srcB1 !== 4'hF) begin miscompares++; $display("FAIL inval_src got %h/%h exp F/F", srcA1, srcB1); end
      tick(); dec_en = 0; wb_en = 1; valE = 64'h1; valM = 64'h2; #1;
      vectors++; if (dE1 !== 4'hF || dM1 !== 4'hF) begin miscompares++; $display("FAIL inval_dst got %h/%h exp F/F", dE1, dM1); end
      tick(); idle(); dbg_sel = 4'h2; #1;
      vectors++; if (dbg1 !== 64'd0) begin miscompares++; $display("FAIL inval_nowrite got %h exp 0", dbg1); end
   endtask

   task automatic test_random();
      logic [63:0] ea1, eb1, ea0, eb0, ed;
      for (int n = 0; n < 400; n++) begin
         rst    = ($urandom_range(0, 49) == 0);
         icode  = 4'($urandom_range(0, 15));
         rA     = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 14));
         rB     = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 14));
         cnd    = 1'($urandom);
         dec_en = 1'($urandom);
         wb_en  = 1'($urandom);
         valE   = {$urandom, $urandom};
         valM   = {$urandom, $urandom};
         dbg_sel = 4'($urandom_range(0, 15));
         #1;
         ea1 = m_read(e_srcA(icode, rA), 1'b1); eb1 = m_read(e_srcB(icode, rB), 1'b1);
         ea0 = m_read(e_srcA(icode, rA), 1'b0); eb0 = m_read(e_srcB(icode, rB), 1'b0);
         ed  = (dbg_sel == 4'hF) ? 64'd0 : m_reg[dbg_sel];
         vectors++; if (srcA1 !== e_srcA(icode, rA) || srcB1 !== e_srcB(icode, rB)) begin miscompares++; $display("FAIL rnd_src n=%0d got %h/%h exp %h/%h", n, srcA1, srcB1, e_srcA(icode, rA), e_srcB(icode, rB)); end
         vectors++; if (valA1 !== ea1 || valB1 !== eb1) begin miscompares++; $display("FAIL rnd_val_byp n=%0d got %h/%h exp %h/%h", n, valA1, valB1, ea1, eb1); end
         vectors++; if (valA0 !== ea0 || valB0 !== eb0) begin miscompares++; $display("FAIL rnd_val_nobyp n=%0d got %h/%h exp %h/%h", n, valA0, valB0, ea0, eb0); end
         vectors++; if (dE1 !== m_dE || dM1 !== m_dM) begin miscompares++; $display("FAIL rnd_dst n=%0d got %h/%h exp %h/%h", n, dE1, dM1, m_dE, m_dM); end
         vectors++; if (dbg1 !== ed || dbg0 !== ed) begin miscompares++; $display("FAIL rnd_dbg n=%0d got %h/%h exp %h", n, dbg1, dbg0, ed); end
         tick();
      end
   endtask

   initial begin
      valE = '0; valM = '0; dbg_sel = 4'h0;
      for (int i = 0; i < 15; i++) m_reg[i] = 64'd0;
      m_dE = 4'hF; m_dM = 4'hF;
      idle();
      test_reset();
      test_irmovq();
      test_opq_bypass();
      test_cmov();
      test_popq_rsp();
      test_reset_midwb();
      idle(); rst = 1; tick(); rst = 0;
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
